// File: rtl/viscosity_capture.sv
// viscosity_capture
//   Multi-channel sensor decimator with a set-wide FIFO and an AXI-Stream
//   serialiser toward the PS DMA. Each accepted sample set is summed over a
//   window of 2^dec_log2 samples, then floor-averaged by an arithmetic right shift.
//   Each completed set is queued in the FIFO and sent as NUM_CH beats, channel 0
//   first. m_tlast marks the last beat of every frame_len-th set.
//
// Optional feature: define VISCOSITY_CAPTURE_OVF_CNT_EN to add the saturating
//   ovf_count output (number of dropped sets).
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   enable            capture enable (1->0 discards the partial window)
//   dec_log2          decimation exponent, sampled at window start
//   frame_len         sets per output frame (0 behaves as 1)
//   s_valid, s_data   input sample set, channel k in [k*DATA_W +: DATA_W]
//   m_t*              AXI-Stream master (tvalid/tready/tdata/tchan/tlast)
//   ovf_clr           pulse clearing the sticky overflow flag
//   overflow          sticky flag: a completed set was dropped (FIFO full)
//   ovf_count         (optional) saturating dropped-set counter
//   fifo_level        number of sets stored, including the one being sent
module viscosity_capture #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               dec_log2,
  input  logic [15:0]              frame_len,
  input  logic                     s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [CH_W-1:0]          m_tchan,
  output logic                     m_tlast,
  input  logic                     ovf_clr,
  output logic                     overflow,
`ifdef VISCOSITY_CAPTURE_OVF_CNT_EN
  output logic [15:0]              ovf_count,
`endif
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int ACC_W = DATA_W + 7;   // headroom for 2^7 samples
  localparam int AW    = $clog2(DEPTH);
  localparam int SET_W = NUM_CH * DATA_W;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // ---------------------------------------------------------------- decimator
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic signed [ACC_W-1:0] sum [NUM_CH];
  logic [SET_W-1:0]        avg_set;
  logic [SET_W-1:0]        set_data;
  logic                    set_pend;
  logic [6:0]              dec_cnt;
  logic [6:0]              win_mask;
  logic [2:0]              dec_cur;
  logic [2:0]              dec_eff;
  logic                    accept;
  logic                    win_last;

  always_comb begin
    // NOTE: every always_comb output gets a value before any branch or loop, so no latch is inferred.
    avg_set  = '0;
    accept   = enable & s_valid;
    // dec_log2 is only honoured at the start of a window.
    dec_eff  = (dec_cnt == '0) ? dec_log2 : dec_cur;
    win_mask = 7'((8'd1 << dec_eff) - 8'd1);
    win_last = (dec_cnt == win_mask);
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k] = acc[k] + ACC_W'($signed(s_data[k*DATA_W +: DATA_W]));
      // Arithmetic shift of the signed sum gives the floor average.
      avg_set[k*DATA_W +: DATA_W] = DATA_W'(sum[k] >>> dec_eff);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      dec_cnt  <= '0;
      dec_cur  <= '0;
      set_data <= '0;
      set_pend <= 1'b0;
    end else begin
      set_pend <= 1'b0;
      if (!enable) begin
        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        dec_cnt <= '0;
      end else if (accept) begin
        if (dec_cnt == '0) dec_cur <= dec_log2;
        if (win_last) begin
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          dec_cnt  <= '0;
          set_data <= avg_set;
          set_pend <= 1'b1;   // written to the FIFO on the next edge
        end else begin
          for (int k = 0; k < NUM_CH; k++) acc[k] <= sum[k];
          dec_cnt <= dec_cnt + 7'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------- FIFO
  // The head entry is popped only after its last beat is accepted, so
  // fifo_level counts the set currently being serialised.
  logic [SET_W-1:0] mem [DEPTH];
  logic [SET_W-1:0] head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             drop;
  logic             out_active;
  logic [CH_W-1:0]  ch_idx;
  logic [15:0]      frame_cnt;
  logic [15:0]      frame_last;
  logic             beat_hs;
  logic             set_hs;

  always_comb begin
    beat_hs   = out_active & m_tready;
    set_hs    = beat_hs & (ch_idx == LAST_CH);
    fifo_rd   = set_hs;
    // A full FIFO still accepts a set when a pop happens in the same cycle.
    fifo_wr   = set_pend & ((fifo_level != FULL_LVL) | fifo_rd);
    drop      = set_pend & ~fifo_wr;
    level_nxt = fifo_level + LVL_W'(fifo_wr) - LVL_W'(fifo_rd);
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= set_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_nxt;
    end
  end

  // ---------------------------------------------------------------- serialiser
  always_comb begin
    head       = mem[rd_ptr];
    frame_last = (frame_len == 16'd0) ? 16'd0 : frame_len - 16'd1;
    m_tvalid   = out_active;
    m_tchan    = ch_idx;
    m_tdata    = out_active ? head[ch_idx*DATA_W +: DATA_W] : '0;
    m_tlast    = out_active & (ch_idx == LAST_CH) & (frame_cnt >= frame_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_active <= 1'b0;
      ch_idx     <= '0;
      frame_cnt  <= '0;
    end else begin
      // Valid rises one cycle after the FIFO becomes non-empty; back-to-back
      // sets stream without a bubble.
      if (!out_active)  out_active <= (fifo_level != '0);
      else if (set_hs)  out_active <= (level_nxt != '0);
      if (set_hs)       ch_idx <= '0;
      else if (beat_hs) ch_idx <= ch_idx + CH_W'(1);
      if (set_hs)       frame_cnt <= m_tlast ? 16'd0 : frame_cnt + 16'd1;
    end
  end

  // ----------------------------------------------------------------- overflow
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef VISCOSITY_CAPTURE_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              ovf_count <= '0;
    else if (ovf_clr)                     ovf_count <= drop ? 16'd1 : 16'd0;
    else if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule

// File: doc/viscosity_capture.md
VISCOSITY_CAPTURE -- requirements
Module: viscosity_capture

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sensor channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, signed sample width per channel.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO depth in sample sets (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  capture enable.
REQ-007 SHALL have port dec_log2  input  3  decimation factor = 2^dec_log2.
REQ-008 SHALL have port frame_len  input  16  sample sets per output frame.
REQ-009 SHALL have port s_valid  input  1  qualifies s_data.
REQ-010 SHALL have port s_data  input  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have ports m_tvalid out 1, m_tready in 1, m_tdata out DATA_W, m_tchan out clog2(NUM_CH) (min 1), m_tlast out 1: AXI-Stream master to the PS DMA.
REQ-012 SHALL have port ovf_clr  input  1  single-cycle pulse that clears overflow.
REQ-013 SHALL have port overflow  output  1  sticky dropped-set flag.
REQ-014 SHALL have port fifo_level  output  clog2(DEPTH)+1  stored sets.

Function
REQ-015 SHALL, per channel, sum 2^dec_log2 consecutive accepted samples (sign-extended to DATA_W+7 bits), then form the average by arithmetic right shift by dec_log2 (floor), giving DATA_W bits.
REQ-016 SHALL accept a sample only when s_valid=1 and enable=1; all other s_data is ignored.
REQ-017 SHALL sample dec_log2 only when the decimation counter is 0; changes mid-window take effect at the next window.
REQ-018 SHALL write the completed NUM_CH-wide set into the FIFO on the cycle after the final accepted sample; with dec_log2=0, every accepted sample is a set.
REQ-019 SHALL, when a set completes and the FIFO is full, drop the whole set and set overflow to 1; the FIFO is never overwritten.
REQ-020 SHALL clear overflow on ovf_clr unless a drop occurs in the same cycle, in which case overflow stays 1.
REQ-021 SHALL serialise each FIFO set as NUM_CH beats, channel 0 first, with m_tchan = channel index.
REQ-022 SHALL assert m_tvalid two cycles after the final accepted sample when the FIFO was empty and the output was idle.
REQ-023 SHALL hold m_tdata, m_tchan and m_tlast stable while m_tvalid=1 and m_tready=0, and never deassert m_tvalid without a handshake.
REQ-024 SHALL assert m_tlast on the last channel beat of every frame_len-th set output; frame_len=0 is treated as 1; the frame counter wraps to 0 after m_tlast.
REQ-025 SHALL sustain one beat per cycle with m_tready held high; FIFO write and read in the same cycle SHALL leave fifo_level unchanged, including when full.
REQ-026 SHALL, on enable 1->0, discard the partial accumulation and clear the decimation counter; stored sets continue to drain and the frame counter is unchanged.

Reset
REQ-027 SHALL, on rst, clear the accumulators, decimation counter, frame counter, channel index and FIFO pointers.
REQ-028 SHALL drive m_tvalid=0, m_tdata=0, m_tchan=0, m_tlast=0, overflow=0 and fifo_level=0 in the cycle after rst is sampled high; rst mid-frame abandons that frame with no m_tlast.

Configuration
REQ-029 SHALL, with macro VISCOSITY_CAPTURE_OVF_CNT_EN defined, add output ovf_count (16 bits) that counts dropped sets, saturates at 0xFFFF, and clears on rst or ovf_clr; a drop coincident with ovf_clr loads 1.
REQ-030 SHALL, without VISCOSITY_CAPTURE_OVF_CNT_EN, omit the ovf_count port and its logic entirely.

Verification
REQ-031 SHALL cover: NUM_CH=2, dec_log2=2, ch0 samples 4,5,6,7 -> one set, ch0 beat 5 (22>>2), m_tvalid 2 cycles after the 4th sample.
REQ-032 SHALL cover: ch0 samples -1,-2 with dec_log2=1 -> m_tdata=0xFFFE (-3>>1 = -2, floor).
REQ-033 SHALL cover: DEPTH=16, m_tready=0, 17 sets -> fifo_level=16, overflow=1, 17th set absent from output, ovf_count=1 when the macro is enabled.
REQ-034 SHALL cover: frame_len=3, NUM_CH=2, 6 sets with random m_tready -> m_tlast on beats 6 and 12 only, with data stable under stall.
REQ-035 SHALL cover: rst pulsed with 5 sets stored and a frame partly sent -> all outputs 0 next cycle, and the next frame starts at channel 0 set 0.
